// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator: format codes,
// legal datapath widths and the output buffer occupancy states.
package imm_pkg;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_RSVD  = 3'b111
  } imm_src_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == XLEN_32) || (xlen == XLEN_64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: picks the format fields out of the
// instruction and sign- or zero-extends them to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     Instr,
  input  logic [2:0]      ImmSrc,
  output logic [XLEN-1:0] ImmExt,
  output logic            ImmErr
);

  imm_src_e    src;
  logic [31:0] raw;
  logic        sext;

  assign src = imm_src_e'(ImmSrc);

  // raw is the 32-bit form; sext says whether bit 31 extends past 32 bits.
  always_comb begin
    raw    = '0;
    sext   = 1'b0;
    ImmErr = 1'b0;
    case (src)
      IMM_I: begin
        raw  = {{20{Instr[31]}}, Instr[31:20]};
        sext = 1'b1;
      end
      IMM_S: begin
        raw  = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
        sext = 1'b1;
      end
      IMM_B: begin
        raw  = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
        sext = 1'b1;
      end
      IMM_J: begin
        raw  = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
        sext = 1'b1;
      end
      IMM_U: begin
        raw  = {Instr[31:12], 12'b0};
        sext = 1'b1;
      end
      IMM_SHAMT: begin
        raw = (XLEN == XLEN_64) ? {26'b0, Instr[25:20]} : {27'b0, Instr[24:20]};
      end
      IMM_ZIMM: begin
        raw = {27'b0, Instr[19:15]};
      end
      IMM_RSVD: begin
        ImmErr = 1'b1;
      end
      default: begin
        ImmErr = 1'b1;
      end
    endcase
  end

  if (XLEN == XLEN_64) begin : g_x64
    assign ImmExt = {{32{sext & raw[31]}}, raw};
  end else begin : g_x32
    assign ImmExt = raw;
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator with valid/ready flow control and a
// two-entry (main + skid) output buffer for full throughput under stall.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:7]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] OutTag,
  output logic             ImmErr,
  output pipe_state_e      DbgState
);

  // Handshake: an item moves on a side only in a cycle where that side's
  // valid and ready are both high at the rising edge; ready never depends
  // combinationally on the opposite side's signals.

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             err;
    logic [TAG_W-1:0] tag;
  } item_t;

  pipe_state_e     state_q, state_d;
  item_t           main_q, main_d;
  item_t           skid_q, skid_d;
  item_t           in_item;
  logic [XLEN-1:0] dec_imm;
  logic            dec_err;
  logic            accept;
  logic            xfer;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .Instr  (Instr),
    .ImmSrc (ImmSrc),
    .ImmExt (dec_imm),
    .ImmErr (dec_err)
  );

  assign in_item  = {dec_imm, dec_err, InTag};
  assign InReady  = (state_q != ST_FULL) & ~rst;
  assign OutValid = (state_q != ST_EMPTY);
  assign accept   = InValid & InReady;
  assign xfer     = OutValid & OutReady;

  assign ImmExt   = main_q.imm;
  assign ImmErr   = main_q.err;
  assign OutTag   = main_q.tag;
  assign DbgState = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_item;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          main_d = in_item;
        end else if (accept) begin
          skid_d  = in_item;
          state_d = ST_FULL;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances on shared inputs,
// directed cases plus a random stream checked against a queue model.
module tb_imm_extend_pipe;
  import imm_pkg::*;

  localparam int TAG_W = 5;
  localparam int N_RAND = 10000;
  localparam int RAND_BUDGET = 40000;

  logic             clk = 1'b0;
  logic             rst;
  logic             InValid;
  logic [31:7]      Instr;
  logic [2:0]       ImmSrc;
  logic [TAG_W-1:0] InTag;
  logic             OutReady;

  logic             rdy32, rdy64, val32, val64, err32, err64;
  logic [31:0]      imm32;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] tag32, tag64;
  pipe_state_e      st32, st64;

  imm_extend_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(rdy32), .Instr(Instr),
    .ImmSrc(ImmSrc), .InTag(InTag), .OutValid(val32), .OutReady(OutReady),
    .ImmExt(imm32), .OutTag(tag32), .ImmErr(err32), .DbgState(st32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(rdy64), .Instr(Instr),
    .ImmSrc(ImmSrc), .InTag(InTag), .OutValid(val64), .OutReady(OutReady),
    .ImmExt(imm64), .OutTag(tag64), .ImmErr(err64), .DbgState(st64)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Packed as {err, tag, value at XLEN=64, value at XLEN=32}.
  localparam int W = 1 + TAG_W + 64 + 32;

  function automatic logic [W-1:0] ref_item(input logic [31:7] ins, input logic [2:0] src,
                                            input logic [TAG_W-1:0] tag);
    longint one = 1;
    longint v = 0;
    longint v64;
    logic   err = 1'b0;
    case (src)
      3'd0: begin
        v = longint'(ins[31:20]);
        if (v >= (one << 11)) v -= (one << 12);
      end
      3'd1: begin
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= (one << 11)) v -= (one << 12);
      end
      3'd2: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= (one << 12)) v -= (one << 13);
      end
      3'd3: begin
        v = longint'(ins[31]) * (one << 20) + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= (one << 20)) v -= (one << 21);
      end
      3'd4: begin
        v = longint'(ins[31:12]) * 4096;
        if (v >= (one << 31)) v -= (one << 32);
      end
      3'd5: v = longint'(ins[24:20]);
      3'd6: v = longint'(ins[19:15]);
      default: begin
        v   = 0;
        err = 1'b1;
      end
    endcase
    v64 = (src == 3'd5) ? longint'(ins[25:20]) : v;
    return {err, tag, v64[63:0], v[31:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   e;
  logic [127:0]   held;
  logic           stall_q = 1'b0;
  int             n_acc = 0;

  // Inputs change just after the rising edge, so values at the falling edge
  // are exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_q = 1'b0;
    end else begin
      check("out_valid32", val32, exp_q.size() != 0);
      check("out_valid64", val64, exp_q.size() != 0);
      check("in_ready32", rdy32, exp_q.size() < 2);
      check("in_ready64", rdy64, exp_q.size() < 2);
      if (stall_q)
        check("stable", {err32, tag32, imm32, err64, tag64, imm64}, held);
      if (val32 && OutReady && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("item32", {err32, tag32, imm32}, {e[W-1], e[W-2 -: TAG_W], e[31:0]});
        check("item64", {err64, tag64, imm64}, {e[W-1], e[W-2 -: TAG_W], e[95:32]});
      end
      if (InValid && rdy32) begin
        exp_q.push_back(ref_item(Instr, ImmSrc, InTag));
        n_acc++;
      end
      stall_q = val32 && !OutReady;
      held    = {err32, tag32, imm32, err64, tag64, imm64};
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] full, input logic [2:0] src,
                       input logic [TAG_W-1:0] tag);
    InValid = v;
    Instr   = full[31:7];
    ImmSrc  = src;
    InTag   = tag;
  endtask

  logic [31:0] isb_ins [3] = '{32'hFFF00093, 32'hFE512E23, 32'hFE000CE3};
  logic [31:0] isb_exp [3] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8};
  logic [31:0] jus_ins [3] = '{32'h001000EF, 32'h800000B7, 32'h03F0D093};
  logic [63:0] jus_exp [3] = '{64'h0000000000000800, 64'hFFFFFFFF80000000, 64'h000000000000003F};

  initial begin
    int base;
    int cyc;
    rst = 1'b1;
    OutReady = 1'b0;
    drive(1'b0, 32'h0, 3'd0, '0);
    #2;
    check("rst_valid", val32, 1'b0);
    check("rst_ready", rdy32, 1'b0);
    check("rst_imm", imm64, 64'h0);
    check("rst_tag", tag32, '0);
    check("rst_err", err32, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check("ready_after_rst", rdy32, 1'b1);

    // I/S/B back-to-back, XLEN=32
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, isb_ins[i], 3'(i), 5'(i + 1));
      step();
      check("isb_imm32", imm32, isb_exp[i]);
      check("isb_err", err32, 1'b0);
    end
    // J/U/SHAMT, XLEN=64
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, jus_ins[i], 3'(i + 3), 5'(i + 4));
      step();
      check("jus_imm64", imm64, jus_exp[i]);
    end
    check("shamt_imm32", imm32, 32'h1F);

    // reserved and ZIMM
    drive(1'b1, $urandom(), 3'b111, 5'd7);
    step();
    check("rsvd_imm32", imm32, 32'h0);
    check("rsvd_imm64", imm64, 64'h0);
    check("rsvd_err", err32, 1'b1);
    drive(1'b1, 32'h000F8000, 3'b110, 5'd8);
    step();
    check("zimm_imm32", imm32, 32'h1F);
    check("zimm_err", err64, 1'b0);
    drive(1'b0, 32'h0, 3'd0, '0);
    step();

    // back-pressure: tags 1,2,3 with downstream stalled
    OutReady = 1'b0;
    drive(1'b1, $urandom(), 3'd0, 5'd1);
    step();
    drive(1'b1, $urandom(), 3'd1, 5'd2);
    step();
    drive(1'b1, $urandom(), 3'd2, 5'd3);
    check("bp_full_ready", rdy32, 1'b0);
    check("bp_state", st32, ST_FULL);
    check("bp_tag_hold", tag32, 5'd1);
    step();
    check("bp_tag_hold2", tag32, 5'd1);
    check("bp_full_ready2", rdy32, 1'b0);
    OutReady = 1'b1;
    step();
    check("bp_tag2", tag32, 5'd2);
    step();
    check("bp_tag3", tag32, 5'd3);
    drive(1'b0, 32'h0, 3'd0, '0);
    step();
    check("bp_drained", val32, 1'b0);

    // asynchronous reset while FULL
    OutReady = 1'b0;
    drive(1'b1, $urandom(), 3'd4, 5'd11);
    step();
    drive(1'b1, $urandom(), 3'd5, 5'd12);
    step();
    drive(1'b0, 32'h0, 3'd0, '0);
    check("pre_rst_state", st64, ST_FULL);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", val32, 1'b0);
    check("mid_rst_ready", rdy64, 1'b0);
    check("mid_rst_state", st32, ST_EMPTY);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_ready", rdy32, 1'b1);
    step();
    check("post_rst_idle", val64, 1'b0);
    OutReady = 1'b1;
    drive(1'b1, 32'h000F8000, 3'b110, 5'd9);
    step();
    check("post_rst_tag", tag32, 5'd9);
    check("post_rst_imm", imm32, 32'h1F);
    drive(1'b0, 32'h0, 3'd0, '0);
    step();

    // random stream
    base = n_acc;
    cyc = 0;
    while ((n_acc - base) < N_RAND && cyc < RAND_BUDGET) begin
      drive(($urandom_range(0, 9) < 7), $urandom(), 3'($urandom_range(0, 7)),
            TAG_W'($urandom_range(0, (1 << TAG_W) - 1)));
      OutReady = ($urandom_range(0, 9) < 7);
      step();
      cyc++;
    end
    drive(1'b0, 32'h0, 3'd0, '0);
    OutReady = 1'b1;
    check("rand_count", n_acc - base, N_RAND);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    check("rand_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
